// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback with memory wait states.
// Optional retired-instruction counter enabled by defining MC_PERF_CNT_EN.
module mips_multicycle_ctrl #(
    parameter bit WAIT_MEM = 1'b1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic [5:0]       Funct,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             Branch,
    output logic [1:0]       PCSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q, state_d;
    logic   mem_rdy;

    assign mem_rdy = (WAIT_MEM == 1'b0) || mem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = S_FETCH;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        PCSrc      = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b000;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB    = 2'b01;
                ALUControl = 3'b010;
                IRWrite    = mem_rdy;
                PCWrite    = mem_rdy;
                state_d    = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = 3'b010;
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = 3'b010;
                if (Opcode == OP_LW)      state_d = S_MEMREAD;
                else if (Opcode == OP_SW) state_d = S_MEMWRITE;
                else                      state_d = S_FETCH;
            end
            S_MEMREAD: begin
                IorD    = 1'b1;
                state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                state_d  = mem_rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                state_d = S_ALUWB;
                case (Funct)
                    6'b100000: ALUControl = 3'b010;
                    6'b100010: ALUControl = 3'b110;
                    6'b100100: ALUControl = 3'b000;
                    6'b100101: ALUControl = 3'b001;
                    6'b101010: ALUControl = 3'b111;
                    default: begin
                        ALUControl = 3'b010;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = 3'b110;
                Branch     = 1'b1;
                PCSrc      = 2'b01;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = 3'b010;
                state_d    = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // While reset is held the FETCH strobes must not leak out, so nothing is written.
        if (!reset) begin
            IorD       = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            Branch     = 1'b0;
            PCSrc      = 2'b00;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            ALUControl = 3'b000;
            RegDst     = 1'b0;
            MemtoReg   = 1'b0;
            RegWrite   = 1'b0;
            illegal_op = 1'b0;
        end
    end

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             retire;

    // Only normal completions retire; the illegal-opcode exit from DECODE is excluded.
    assign retire = (state_d == S_FETCH) &&
                    (state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      cnt_q <= '0;
        else if (retire) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign instr_count = cnt_q;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class state by state and checks all strobes.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       mem_ready;
    logic       IorD, MemWrite, IRWrite, PCWrite, Branch;
    logic [1:0] PCSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic       RegDst, MemtoReg, RegWrite, illegal_op;
    logic [3:0] instr_count;

    int         err_cnt = 0;
    int         chk_cnt = 0;
    logic [3:0] exp_cnt = 4'd0;
    logic [16:0] obs;

    mips_multicycle_ctrl #(.WAIT_MEM(1'b1), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .mem_ready(mem_ready),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .Branch(Branch), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .illegal_op(illegal_op), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign obs = {IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB,
                  ALUControl, RegDst, MemtoReg, RegWrite, illegal_op};

    function automatic logic [16:0] cv(input logic iord, mw, irw, pcw, br, input logic [1:0] pcsrc,
                                       input logic srca, input logic [1:0] srcb, input logic [2:0] aluc,
                                       input logic rd, m2r, rw, ill);
        return {iord, mw, irw, pcw, br, pcsrc, srca, srcb, aluc, rd, m2r, rw, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [16:0] V_ZERO, V_F, V_FS, V_D, V_DILL, V_MA, V_MR, V_MWB, V_MW;
    logic [16:0] V_AWB, V_BR, V_AEX, V_AIWB, V_J;

    // Check strobes of the current state, then advance one clock.
    task automatic st(input string tag, input logic [16:0] e);
        #1;
        check(tag, {15'd0, obs}, {15'd0, e});
        @(posedge clk);
        #1;
    endtask

    task automatic done(input string tag);
`ifdef MC_PERF_CNT_EN
        exp_cnt = exp_cnt + 4'd1;
`endif
        check(tag, {28'd0, instr_count}, {28'd0, exp_cnt});
    endtask

    task automatic run_lw();
        Opcode = 6'b100011; mem_ready = 1'b1;
        st("lw_fetch", V_F); st("lw_decode", V_D); st("lw_memadr", V_MA);
        st("lw_memread", V_MR); st("lw_memwb", V_MWB);
        done("lw_cnt");
    endtask

    task automatic run_sw_wait2();
        Opcode = 6'b101011; mem_ready = 1'b1;
        st("sw_fetch", V_F); st("sw_decode", V_D); st("sw_memadr", V_MA);
        mem_ready = 1'b0;
        st("sw_mw1", V_MW); st("sw_mw2", V_MW);
        mem_ready = 1'b1;
        st("sw_mw3", V_MW);
        done("sw_cnt");
    endtask

    task automatic run_r(input logic [5:0] f, input logic [2:0] aluc, input logic ill);
        Opcode = 6'b000000; Funct = f; mem_ready = 1'b1;
        st("r_fetch", V_F); st("r_decode", V_D);
        st("r_execute", cv(0,0,0,0,0,2'b00,1,2'b00,aluc,0,0,0,ill));
        st("r_aluwb", V_AWB);
        done("r_cnt");
    endtask

    task automatic run_beq();
        Opcode = 6'b000100; mem_ready = 1'b1;
        st("beq_fetch", V_F); st("beq_decode", V_D); st("beq_branch", V_BR);
        done("beq_cnt");
    endtask

    task automatic run_j();
        Opcode = 6'b000010; mem_ready = 1'b1;
        st("j_fetch", V_F); st("j_decode", V_D); st("j_jump", V_J);
        done("j_cnt");
    endtask

    task automatic run_addi();
        Opcode = 6'b001000; mem_ready = 1'b1;
        st("addi_fetch", V_F); st("addi_decode", V_D); st("addi_ex", V_AEX); st("addi_wb", V_AIWB);
        done("addi_cnt");
    endtask

    task automatic run_illegal();
        Opcode = 6'b111111; mem_ready = 1'b1;
        st("ill_fetch", V_F); st("ill_decode", V_DILL);
        #1;
        check("ill_back_fetch", {15'd0, obs}, {15'd0, V_F});
        check("ill_no_cnt", {28'd0, instr_count}, {28'd0, exp_cnt});
    endtask

    initial begin
        V_ZERO = '0;
        V_F    = cv(0,0,1,1,0,2'b00,0,2'b01,3'b010,0,0,0,0);
        V_FS   = cv(0,0,0,0,0,2'b00,0,2'b01,3'b010,0,0,0,0);
        V_D    = cv(0,0,0,0,0,2'b00,0,2'b11,3'b010,0,0,0,0);
        V_DILL = cv(0,0,0,0,0,2'b00,0,2'b11,3'b010,0,0,0,1);
        V_MA   = cv(0,0,0,0,0,2'b00,1,2'b10,3'b010,0,0,0,0);
        V_MR   = cv(1,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,0);
        V_MWB  = cv(0,0,0,0,0,2'b00,0,2'b00,3'b000,0,1,1,0);
        V_MW   = cv(1,1,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,0);
        V_AWB  = cv(0,0,0,0,0,2'b00,0,2'b00,3'b000,1,0,1,0);
        V_BR   = cv(0,0,0,0,1,2'b01,1,2'b00,3'b110,0,0,0,0);
        V_AEX  = cv(0,0,0,0,0,2'b00,1,2'b10,3'b010,0,0,0,0);
        V_AIWB = cv(0,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,1,0);
        V_J    = cv(0,0,0,1,0,2'b10,0,2'b00,3'b000,0,0,0,0);

        reset = 1'b0; Opcode = 6'd0; Funct = 6'd0; mem_ready = 1'b1;
        #1;
        check("rst_strobes", {15'd0, obs}, {15'd0, V_ZERO});
        @(posedge clk); @(posedge clk); #1;
        check("rst_strobes_hold", {15'd0, obs}, {15'd0, V_ZERO});
        check("rst_cnt", {28'd0, instr_count}, 32'd0);
        reset = 1'b1;

        run_lw();
        run_sw_wait2();
        run_r(6'b101010, 3'b111, 1'b0);
        run_r(6'b100010, 3'b110, 1'b0);
        run_r(6'b111111, 3'b010, 1'b1);
        run_beq();
        run_j();
        mem_ready = 1'b0;
        st("fetch_stall1", V_FS);
        st("fetch_stall2", V_FS);
        run_addi();
        run_illegal();

        // Reset while stalled in MEMREAD.
        Opcode = 6'b100011; mem_ready = 1'b1;
        st("rlw_fetch", V_F); st("rlw_decode", V_D); st("rlw_memadr", V_MA);
        mem_ready = 1'b0;
        st("rlw_memread", V_MR);
        check("rlw_still_memread", {15'd0, obs}, {15'd0, V_MR});
        reset = 1'b0;
        #1;
        check("midrst_strobes", {15'd0, obs}, {15'd0, V_ZERO});
        mem_ready = 1'b1;
        #1;
        check("midrst_gated", {15'd0, obs}, {15'd0, V_ZERO});
        @(posedge clk); #1;
        check("midrst_hold", {15'd0, obs}, {15'd0, V_ZERO});
        check("midrst_cnt", {28'd0, instr_count}, 32'd0);
        exp_cnt = 4'd0;
        reset = 1'b1;

        run_illegal();
        for (int i = 0; i < 17; i++) run_addi();
`ifdef MC_PERF_CNT_EN
        check("cnt_wrap17", {28'd0, instr_count}, 32'd1);
`else
        check("cnt_tied0", {28'd0, instr_count}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style control FSM that sequences a multi-cycle MIPS datapath: shared memory, IR, A/B/ALUOut registers, a single ALU.
- Decodes Opcode/Funct and issues per-state control strobes.
- Supports memory wait states via a ready handshake.
- Sits beside the datapath and replaces the combinational single-cycle control unit.

Parameters:
- WAIT_MEM, 1, 1 = honour mem_ready in memory states; 0 = mem_ready ignored and treated as 1.
- CNT_W, 32, width of the retired-instruction counter (Optional Feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Opcode  in  6  instr[31:26] from IR.
- Funct  in  6  instr[5:0] from IR.
- mem_ready  in  1  memory completes the current access this cycle.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  load IR.
- PCWrite  out  1  unconditional PC load.
- Branch  out  1  conditional PC load; datapath forms PCEn = PCWrite | (Branch & Zero).
- PCSrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = A register.
- ALUSrcB  out  2  ALU B input: 00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2.
- ALUControl  out  3  ALU operation code.
- RegDst  out  1  destination register: 1 = rd, 0 = rt.
- MemtoReg  out  1  writeback source: 1 = memory data, 0 = ALUOut.
- RegWrite  out  1  register-file write enable.
- illegal_op  out  1  one-cycle pulse when an unknown opcode is decoded.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- State register, async clear to FETCH when reset = 0. All strobes default to 0 in every state unless listed below.
- Unlisted state encodings go to FETCH.
- FETCH: IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUControl = 010, PCSrc = 00.
  - IRWrite = PCWrite = mem_ready (Mealy-qualified).
  - Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUControl = 010 (branch target into ALUOut). Next state by Opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXECUTE
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other opcode -> FETCH, with illegal_op = 1 for that cycle.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUControl = 010. lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD: IorD = 1. Hold while mem_ready = 0; then -> MEMWB.
- MEMWB: RegDst = 0, MemtoReg = 1, RegWrite = 1. -> FETCH.
- MEMWRITE: IorD = 1, MemWrite = 1 for every cycle in the state. Hold while mem_ready = 0; then -> FETCH.
- EXECUTE: ALUSrcA = 1, ALUSrcB = 00, ALUControl from Funct:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - any other Funct -> 010, plus illegal_op pulse.
  - Next state: ALUWB.
- ALUWB: RegDst = 1, MemtoReg = 0, RegWrite = 1. -> FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUControl = 110, Branch = 1, PCSrc = 01. -> FETCH.
- ADDIEX: ALUSrcA = 1, ALUSrcB = 10, ALUControl = 010. -> ADDIWB.
- ADDIWB: RegDst = 0, MemtoReg = 0, RegWrite = 1. -> FETCH.
- JUMP: PCSrc = 10, PCWrite = 1. -> FETCH.
- Cycle counts with zero wait states:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each mem_ready = 0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Reset asserted mid-instruction: immediate return to FETCH with all strobes 0. No partial write completes after reset falls.
- WAIT_MEM = 0: memory states never stall.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- Defined:
  - instr_count increments on every transition into FETCH from a completing state (MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB, JUMP).
  - Not incremented on the illegal-opcode exit.
  - Wraps modulo 2^CNT_W.
  - Async-cleared to 0 by reset.
- Undefined: instr_count tied to 0; no counter flops.

Test Plan:
- Reset: reset = 0 mid-MEMREAD -> state FETCH, RegWrite = MemWrite = PCWrite = 0. After reset = 1 with mem_ready = 1 -> IRWrite = PCWrite = 1 on the first cycle.
- lw, mem_ready = 1 always: Opcode = 100011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB (5 cycles). MemtoReg = RegWrite = 1 only in cycle 5.
- sw with 2 wait cycles: mem_ready low for 2 cycles in MEMWRITE -> MemWrite = 1 for 3 consecutive cycles, then FETCH. Total 6 cycles.
- R-type: Funct = 101010 -> ALUControl = 111 in EXECUTE, RegDst = 1 and RegWrite = 1 in ALUWB. Repeat with Funct 100010 -> ALUControl = 110.
- beq and j: beq -> Branch = 1, PCSrc = 01, ALUControl = 110 in cycle 3. j -> PCSrc = 10, PCWrite = 1 in cycle 3.
- Illegal opcode and counter: Opcode = 111111 -> illegal_op high for exactly 1 cycle, return to FETCH, no RegWrite or MemWrite. With MC_PERF_CNT_EN, CNT_W = 4: after 17 completed addi, instr_count = 1.
